// File: rtl/posit_enc_sched.sv
// posit_enc_sched: round-robin front end for a shared posit encoder.
// Four requesters compete for one encoder; one transaction is in flight
// at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Optional feature macro: POSIT_SCHED_WDOG_EN adds a WAIT-state watchdog
// that returns rsp_err=1 / rsp_posit=0 if the encoder never answers.
module posit_enc_sched #(
  parameter logic [7:0] WDOG_MAX = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [3:0]   req_sign,
  input  logic [23:0]  req_k,
  input  logic [11:0]  req_exp,
  input  logic [127:0] req_mant,
  output logic         enc_start,
  output logic         enc_sign,
  output logic [5:0]   enc_k,
  output logic [2:0]   enc_exp,
  output logic [31:0]  enc_mant,
  input  logic [31:0]  enc_p,
  input  logic         enc_done,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_id,
  output logic [31:0]  rsp_posit,
  output logic         rsp_err,
  output logic         busy
);

  localparam int NUM_LANES = 4;

  // The watchdog timeout compares against WDOG_MAX-2, so it must be >= 2.
  if (WDOG_MAX < 8'd2) begin : g_wdog_chk
    $error("WDOG_MAX must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic       sign;
    logic [5:0] k;
    logic [2:0] exp;
    logic [31:0] mant;
  } lane_req_t;

  lane_req_t [NUM_LANES-1:0] lanes;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = {req_sign[g], req_k[g*6 +: 6], req_exp[g*3 +: 3],
                       req_mant[g*32 +: 32]};
  end

  state_t    state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [1:0] id_q, id_d;
  lane_req_t lane_q, lane_d;
  logic [31:0] posit_q, posit_d;

  logic       found;
  logic [1:0] win;

  // Round-robin search starting at rr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (!found && req_valid[rr_q + 2'(j)]) begin
        found = 1'b1;
        win   = rr_q + 2'(j);
      end
    end
  end

  assign req_ready = (state_q == IDLE && found) ? (4'b0001 << win) : 4'b0000;

`ifdef POSIT_SCHED_WDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
  logic       wdog_hit;

  // RESP lands WDOG_MAX cycles after the enc_start cycle.
  assign wdog_hit = (wdog_q >= WDOG_MAX - 8'd2);

  // Watchdog counter: cleared while issuing, counts WAIT cycles.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ISSUE)     wdog_d = 8'd0;
    else if (state_q == WAIT) wdog_d = wdog_q + 8'd1;
  end

  // Watchdog and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and datapath capture for the transaction FSM.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    lane_d  = lane_q;
    posit_d = posit_q;
`ifdef POSIT_SCHED_WDOG_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          rr_d    = win + 2'd1;
          id_d    = win;
          lane_d  = lanes[win];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A real answer wins over a simultaneous timeout.
        if (enc_done) begin
          state_d = RESP;
          posit_d = enc_p;
`ifdef POSIT_SCHED_WDOG_EN
          err_d   = 1'b0;
        end else if (wdog_hit) begin
          state_d = RESP;
          posit_d = 32'h0000_0000;
          err_d   = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      id_q    <= 2'd0;
      lane_q  <= '0;
      posit_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      lane_q  <= lane_d;
      posit_q <= posit_d;
    end
  end

  assign enc_start = (state_q == ISSUE);
  assign enc_sign  = lane_q.sign;
  assign enc_k     = lane_q.k;
  assign enc_exp   = lane_q.exp;
  assign enc_mant  = lane_q.mant;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_posit = posit_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_posit_enc_sched.sv
// tb_posit_enc_sched: directed + randomized checks of the encoder scheduler
// against a behavioural posit (es=3) encoder stub and a round-robin model.
module tb_posit_enc_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_sign;
  logic [23:0]  req_k;
  logic [11:0]  req_exp;
  logic [127:0] req_mant;
  logic         enc_start, enc_sign;
  logic [5:0]   enc_k;
  logic [2:0]   enc_exp;
  logic [31:0]  enc_mant;
  logic [31:0]  enc_p;
  logic         enc_done;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_posit;
  logic         rsp_err, busy;

  posit_enc_sched #(.WDOG_MAX(8'd8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sign(req_sign), .req_k(req_k), .req_exp(req_exp), .req_mant(req_mant),
    .enc_start(enc_start), .enc_sign(enc_sign), .enc_k(enc_k),
    .enc_exp(enc_exp), .enc_mant(enc_mant), .enc_p(enc_p),
    .enc_done(enc_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_posit(rsp_posit), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;
  int stub_lat = 0;     // 0: random latency 1..5
  bit stub_dead = 1'b0; // encoder never answers
  bit spur_req = 1'b0;  // request a stray enc_done pulse

  // Model state
  logic        l_sign [4];
  logic [5:0]  l_k    [4];
  logic [2:0]  l_exp  [4];
  logic [31:0] l_mant [4];
  int rr_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Posit<32,3>: regime run, 3 exponent bits, fraction, truncated; negate if sign.
  function automatic logic [31:0] posit_ref(input logic s, input logic signed [5:0] k,
                                            input logic [2:0] e, input logic [31:0] m);
    logic [31:0] body;
    int pos, rl;
    body = '0;
    pos  = 30;
    rl   = (k >= 0) ? k + 1 : -k;
    for (int i = 0; i < rl; i++) begin
      if (pos >= 0) body[pos] = (k >= 0);
      pos--;
    end
    if (pos >= 0) body[pos] = (k < 0);
    pos--;
    for (int i = 2; i >= 0; i--) begin
      if (pos >= 0) body[pos] = e[i];
      pos--;
    end
    for (int i = 31; i >= 0; i--) begin
      if (pos >= 0) body[pos] = m[i];
      pos--;
    end
    return s ? -body : body;
  endfunction

  // Encoder stub: answers enc_start after a latency, or pulses a stray done.
  always begin
    @(negedge clk);
    if (rst && enc_start) begin
      logic [31:0] v;
      int lat;
      v   = posit_ref(enc_sign, enc_k, enc_exp, enc_mant);
      lat = (stub_lat > 0) ? stub_lat : int'($urandom_range(1, 5));
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (!rst) break;
      end
      if (rst && !stub_dead) begin
        enc_done = 1'b1;
        enc_p    = v;
        done_cyc = cyc;
        @(negedge clk);
        enc_done = 1'b0;
        enc_p    = $urandom;
      end
    end else if (spur_req) begin
      spur_req = 1'b0;
      enc_done = 1'b1;
      enc_p    = 32'hDEAD_BEEF;
      @(negedge clk);
      enc_done = 1'b0;
    end
  end

  task automatic pack_lanes();
    for (int i = 0; i < 4; i++) begin
      req_sign[i]        = l_sign[i];
      req_k[i*6 +: 6]    = l_k[i];
      req_exp[i*3 +: 3]  = l_exp[i];
      req_mant[i*32 +: 32] = l_mant[i];
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      l_sign[i] = 1'($urandom);
      l_k[i]    = 6'($signed(int'($urandom_range(0, 8)) - 4));
      l_exp[i]  = 3'($urandom);
      l_mant[i] = $urandom;
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m);
    for (int j = 0; j < 4; j++)
      if (m[(rr_m + j) % 4]) return (rr_m + j) % 4;
    return -1;
  endfunction

  // One full transaction starting at a negedge with the DUT idle.
  task automatic run_one(input logic [3:0] vmask, input int hold);
    int w, starts;
    bit got;
    logic [31:0] expp;
    pack_lanes();
    req_valid = vmask;
    #1;
    w = rr_pick(vmask);
    chk("req_ready_grant", {28'd0, req_ready}, 32'(4'b0001 << w));
    rr_m = (w + 1) % 4;
    expp = posit_ref(l_sign[w], l_k[w], l_exp[w], l_mant[w]);
    @(negedge clk);
    req_valid = 4'($urandom);
    chk("enc_start_issue", {31'd0, enc_start}, 32'd1);
    chk("req_ready_busy", {28'd0, req_ready}, 32'd0);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    chk("enc_fields", {enc_sign, enc_k, enc_exp, 22'd0}, {l_sign[w], l_k[w], l_exp[w], 22'd0});
    chk("enc_mant", enc_mant, l_mant[w]);
    starts = 0;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (enc_start) starts++;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("rsp_timeout", {31'd0, got}, 32'd1);
    chk("extra_enc_start", starts, 0);
    chk("rsp_latency", cyc, done_cyc + 1);
    chk("rsp_id", {30'd0, rsp_id}, w);
    chk("rsp_posit", rsp_posit, expp);
    chk("rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("enc_mant_hold", enc_mant, l_mant[w]);
    for (int h = 0; h < hold; h++) begin
      if (h == 1 && hold >= 4) spur_req = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_id", {30'd0, rsp_id}, w);
      chk("hold_posit", rsp_posit, expp);
      chk("hold_ready", {28'd0, req_ready, 3'd0, enc_start}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'd0;
    chk("consumed_valid", {31'd0, rsp_valid}, 32'd0);
    chk("consumed_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, enc_start, rsp_valid, rsp_err, busy, rsp_id},
        32'd0);
    chk({tag, "_enc"}, {enc_sign, enc_k, enc_exp, 22'd0}, 32'd0);
    chk({tag, "_mant"}, enc_mant, 32'd0);
    chk({tag, "_posit"}, rsp_posit, 32'd0);
    chk({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 4'd0; rsp_ready = 1'b0;
    enc_done = 1'b0; enc_p = 32'd0;
    for (int i = 0; i < 4; i++) begin
      l_sign[i] = 1'b0; l_k[i] = 6'd0; l_exp[i] = 3'd0; l_mant[i] = 32'd0;
    end
    pack_lanes();
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Lane 0 all-zero fields -> 1.0
    run_one(4'b0001, 0);
    chk("lane0_posit_const", posit_ref(1'b0, 6'sd0, 3'd0, 32'd0), 32'h4000_0000);

    // Lane 2 k=-1 -> 0x2000_0000 (checked via model); hold 2 cycles
    l_k[2] = 6'h3F;
    run_one(4'b0100, 2);

    // Fresh rr=0, all requesters held: 0,1,2,3,0
    #2 rst = 1'b0; rr_m = 0;
    @(negedge clk); rst = 1'b1; @(negedge clk);
    rand_lanes();
    for (int t = 0; t < 5; t++) begin
      chk("rr_order", rr_m, t % 4);
      run_one(4'b1111, 0);
    end

    // Long response stall with a stray enc_done in RESP
    rand_lanes();
    run_one(4'b0110, 10);

    // Randomized traffic
    for (int t = 0; t < 20; t++) begin
      logic [3:0] m;
      rand_lanes();
      m = 4'($urandom_range(1, 15));
      run_one(m, int'($urandom_range(0, 5)));
    end

    // Lane 1 first so rr=2, then reset in WAIT
    rand_lanes();
    run_one(4'b0010, 0);
    stub_lat = 20;
    pack_lanes();
    req_valid = 4'b1000;
    repeat (4) @(negedge clk);
    req_valid = 4'd0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midreset");
    rr_m = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    stub_lat = 0;
    rand_lanes();
    run_one(4'b1010, 1);

`ifdef POSIT_SCHED_WDOG_EN
    begin
      int s;
      bit got;
      stub_dead = 1'b1;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = 4'd0;
      s = cyc;
      got = 1'b0;
      for (int n = 0; n < 50; n++) begin
        if (rsp_valid) begin got = 1'b1; break; end
        @(negedge clk);
      end
      chk("wdog_timeout", {31'd0, got}, 32'd1);
      chk("wdog_latency", cyc - s, 8);
      chk("wdog_err", {31'd0, rsp_err}, 32'd1);
      chk("wdog_posit", rsp_posit, 32'd0);
      stub_dead = 1'b0;
      spur_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("wdog_late_done", {rsp_posit[30:0], rsp_err}, 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("wdog_consumed", {31'd0, busy}, 32'd0);
      rr_m = 1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_enc_sched.md
POSIT_ENC_SCHED -- requirements
Module: posit_enc_sched

Interface
REQ-001 SHALL have parameter: WDOG_MAX, default 8'd255, watchdog limit in cycles (used only with POSIT_SCHED_WDOG_EN).
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  4  per-requester request strobe.
REQ-005 SHALL have port: req_ready  output  4  per-requester accept, combinational.
REQ-006 SHALL have ports: req_sign input 4; req_k input 24 (4x signed 6b); req_exp input 12 (4x3b); req_mant input 128 (4x32b); lane i at bits [i*W +: W].
REQ-007 SHALL have ports: enc_start output 1; enc_sign output 1; enc_k output 6; enc_exp output 3; enc_mant output 32 (to shared posit encoder).
REQ-008 SHALL have ports: enc_p input 32; enc_done input 1 (from encoder; enc_p valid only in the enc_done cycle).
REQ-009 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_id output 2; rsp_posit output 32; rsp_err output 1; busy output 1.

Function
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; busy = (state != IDLE).
REQ-011 IDLE: req_ready[i] SHALL be 1 only for the round-robin winner i among req_valid bits; all zero in other states.
REQ-012 Round-robin SHALL search from pointer rr (2b) upward, wrapping 3->0; on acceptance rr <= winner+1 mod 4.
REQ-013 On acceptance SHALL register winner id and its sign/k/exp/mant into enc_* outputs; next state ISSUE.
REQ-014 enc_* data outputs SHALL stay constant from ISSUE until return to IDLE.
REQ-015 ISSUE: enc_start SHALL be 1 for exactly one cycle; next state WAIT; enc_start 0 in all other states.
REQ-016 WAIT: on enc_done=1 SHALL capture enc_p into rsp_posit, rsp_err <= 0, next state RESP.
REQ-017 RESP: rsp_valid SHALL be 1; rsp_id, rsp_posit, rsp_err stable until rsp_valid & rsp_ready; then next state IDLE, rsp_valid 0 in the following cycle.
REQ-018 enc_done outside WAIT SHALL be ignored (no state or output change).
REQ-019 No new request SHALL be accepted until the response is consumed; throughput is one transaction per encoder latency + 3 cycles minimum.
REQ-020 Latency: acceptance at cycle T -> enc_start at T+1 -> rsp_valid one cycle after the enc_done cycle.
REQ-021 req_valid deassertion by a non-winner SHALL have no effect; req_valid changes during non-IDLE states SHALL be ignored.

Reset
REQ-022 rst low SHALL asynchronously force: state IDLE, rr 0, enc_start 0, enc_sign 0, enc_k 0, enc_exp 0, enc_mant 0, rsp_valid 0, rsp_id 0, rsp_posit 0, rsp_err 0, busy 0; watchdog counter 0.
REQ-023 Reset mid-transaction SHALL drop it with no response; encoder reset is external (shared rst).

Configuration
REQ-024 Macro POSIT_SCHED_WDOG_EN defined: 8-bit counter cleared in ISSUE, increments each WAIT cycle; reaching WDOG_MAX without enc_done SHALL go to RESP with rsp_err=1, rsp_posit=32'h0000_0000.
REQ-025 POSIT_SCHED_WDOG_EN undefined: no counter, WAIT holds indefinitely, rsp_err tied 0.

Verification
REQ-026 Single req lane 0: sign=0, k=0, exp=0, mant=0 -> one enc_start pulse, rsp_id=0, rsp_posit=32'h4000_0000, rsp_err=0.
REQ-027 Lane 2: sign=0, k=-1, exp=0, mant=0 -> rsp_id=2, rsp_posit=32'h2000_0000.
REQ-028 req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one req_ready bit high per acceptance.
REQ-029 rsp_ready low 10 cycles in RESP -> rsp_valid, rsp_id, rsp_posit unchanged; no req_ready; enc_start stays 0.
REQ-030 With POSIT_SCHED_WDOG_EN, WDOG_MAX=8, encoder stub never asserts enc_done -> rsp_valid 8 cycles after enc_start with rsp_err=1, rsp_posit=0; late enc_done ignored.
REQ-031 rst low during WAIT -> all outputs at reset values immediately; after release, lane 1 request served normally with rr=0 start.
